// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver feeding a small byte FIFO
// with a valid/ready output stream.
// Optional even-parity checking (8E1 framing) is enabled by defining
// UART_RX_PARITY_EN; the default build is plain 8N1.

module uart_rx_fifo #(
   parameter int unsigned BAUD_DIV   = 434,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       uart_rxd,
   output logic [7:0] rx_dat_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err_o
`endif
);

   localparam int unsigned CNT_W  = $clog2(BAUD_DIV);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]  HALF_LD = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_LD = CNT_W'(BAUD_DIV - 1);
   localparam logic [FCNT_W-1:0] FULL_CT = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_BRK    = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      S_PARITY = 3'd5
`endif
   } state_t;

   // ------------------------------------------------------------------
   // Receiver signals
   // ------------------------------------------------------------------
   logic [1:0]       sync_q;
   logic             rxd_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             push;
   logic             frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             parity_err_d;
`endif

   // ------------------------------------------------------------------
   // FIFO signals
   // ------------------------------------------------------------------
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FCNT_W-1:0] count_q, count_d;
   logic              pop;
   logic              full;
   logic              do_push;
   logic              overrun_d;

   assign rxd_s = sync_q[1];
   assign tick  = (cnt_q == '0);

   // Two-flop synchroniser on the asynchronous serial input, idles high
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], uart_rxd};
      end
   end

   // Receiver state register and its datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Received parity bit, held from the parity sample to the stop sample
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   // Framing FSM: start validation, mid-bit sampling, stop check, break hold
   always_comb begin
      state_d     = state_q;
      cnt_d       = tick ? cnt_q : cnt_q - CNT_W'(1);
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rxd_s) begin
               state_d = S_START;
               cnt_d   = HALF_LD;
            end
         end
         S_START: begin
            if (tick) begin
               if (rxd_s) begin
                  // Line went back high before mid-start: glitch, not a start bit
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  cnt_d     = FULL_LD;
                  bit_idx_d = '0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_d   = {rxd_s, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               cnt_d     = FULL_LD;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               par_d   = rxd_s;
               cnt_d   = FULL_LD;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rxd_s) begin
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  // Even parity: data plus parity bit must XOR to zero
                  if (^{shreg_q, par_q}) begin
                     parity_err_d = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
`else
                  push = 1'b1;
`endif
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BRK;
               end
            end
         end
         S_BRK: begin
            // Hold here while the line stays low so a break is not reframed
            if (rxd_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO control: pops always win a slot, so push+pop on a full FIFO is lossless
   always_comb begin
      pop       = rx_valid_o && rx_ready_i;
      full      = (count_q == FULL_CT);
      do_push   = push && (!full || pop);
      overrun_d = push && full && !pop;
      count_d   = count_q;
      case ({do_push, pop})
         2'b10:   count_d = count_q + FCNT_W'(1);
         2'b01:   count_d = count_q - FCNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= shreg_q;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   // Head byte is read straight out of the storage registers
   assign rx_dat_o = mem_q[rd_ptr_q];

   // Registered status and one-cycle event outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         rx_valid_o  <= (count_d != '0);
         frame_err_o <= frame_err_d;
         overrun_o   <= overrun_d;
         busy_o      <= (state_d != S_IDLE);
      end
   end

`ifdef UART_RX_PARITY_EN
   // Registered parity error pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         parity_err_o <= 1'b0;
      end else begin
         parity_err_o <= parity_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (default 8N1 build, BAUD_DIV=8, FIFO_DEPTH=4).

module tb_uart_rx_fifo;

   localparam int unsigned B = 8;
   localparam int unsigned D = 4;
   // Falling edge needs two sync flops plus one IDLE cycle, stop bit is
   // sampled B/2 + 9*B later, and the push shows one cycle after that.
   localparam int unsigned LAT = 3 + B / 2 + 9 * B;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       rxd      = 1'b1;
   logic       ready    = 1'b0;
   logic [7:0] rx_dat;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int rise_cyc = 0;
   logic prev_valid = 1'b0;

   logic [7:0] exp_q[$];
   int start_cyc, fe0, ov0, exp_ov, n_rand, popped, guard, glen;
   logic [7:0] b, e;
   logic r;

   uart_rx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .uart_rxd    (rxd),
      .rx_dat_o    (rx_dat),
      .rx_valid_o  (rx_valid),
      .rx_ready_i  (ready),
      .frame_err_o (frame_err),
      .overrun_o   (overrun),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse counters and valid rising-edge timestamp
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
      prev_valid = rx_valid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drives one frame LSB first; leaves the line at the stop-bit level
   task automatic send_frame(input logic [7:0] byt, input logic stop);
      rxd = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = byt[i];
         repeat (B) @(negedge clk);
      end
      rxd = stop;
      repeat (B) @(negedge clk);
   endtask

   // Checks the head against the model and pops it with a one-cycle ready
   task automatic pop_expect(input string tag);
      logic [7:0] ex;
      check({tag, "_valid"}, 32'(rx_valid), 32'd1);
      if (exp_q.size() > 0) ex = exp_q.pop_front();
      else ex = 8'h00;
      check({tag, "_dat"}, 32'(rx_dat), 32'(ex));
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_dat", 32'(rx_dat), 32'h00);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte, exact push latency, then pop
      start_cyc = cyc;
      send_frame(8'hA5, 1'b1);
      exp_q.push_back(8'hA5);
      repeat (2) @(negedge clk);
      check("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
      pop_expect("a5");
      check("a5_empty", 32'(rx_valid), 32'd0);
      check("a5_idle", 32'(busy), 32'd0);

      // Short low glitches are rejected by the start check
      fe0 = fe_cnt;
      for (int k = 0; k < 3; k++) begin
         glen = $urandom_range(1, 3);
         rxd = 1'b0;
         repeat (glen) @(negedge clk);
         rxd = 1'b1;
         repeat (2 * B) @(negedge clk);
         check("glitch_busy", 32'(busy), 32'd0);
         check("glitch_valid", 32'(rx_valid), 32'd0);
      end
      check("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd0);

      // Stop bit low with line held low: frame error, break hold, recovery
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0);
      repeat (20) @(negedge clk);
      check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_brk_busy", 32'(busy), 32'd1);
      check("ferr_no_push", 32'(rx_valid), 32'd0);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      check("ferr_brk_exit", 32'(busy), 32'd0);
      send_frame(8'h11, 1'b1);
      exp_q.push_back(8'h11);
      repeat (2) @(negedge clk);
      pop_expect("b11");
      check("b11_empty", 32'(rx_valid), 32'd0);

      // Six back-to-back bytes into a depth-4 FIFO with no consumer
      ov0 = ov_cnt;
      exp_ov = 0;
      for (int k = 1; k <= 6; k++) begin
         send_frame(8'(k), 1'b1);
         if (exp_q.size() < D) exp_q.push_back(8'(k));
         else exp_ov++;
      end
      repeat (2) @(negedge clk);
      check("ovr_pulses", 32'(ov_cnt - ov0), 32'(exp_ov));
      for (int k = 0; k < 4; k++) pop_expect("ovr_pop");
      check("ovr_empty", 32'(rx_valid), 32'd0);

      // Full FIFO: the fifth push coincides with a pop
      for (int k = 1; k <= 4; k++) begin
         send_frame(8'(k), 1'b1);
         exp_q.push_back(8'(k));
      end
      ov0 = ov_cnt;
      fork
         send_frame(8'h05, 1'b1);
         begin
            repeat (LAT - 1) @(negedge clk);
            check("coinc_valid", 32'(rx_valid), 32'd1);
            e = exp_q.pop_front();
            check("coinc_head", 32'(rx_dat), 32'(e));
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
         end
      join
      exp_q.push_back(8'h05);
      repeat (2) @(negedge clk);
      check("coinc_no_ovr", 32'(ov_cnt - ov0), 32'd0);
      for (int k = 0; k < 4; k++) pop_expect("coinc_pop");
      check("coinc_empty", 32'(rx_valid), 32'd0);

      // Random bytes against a random-ready consumer, scoreboard in order
      n_rand = $urandom_range(6, 10);
      popped = 0;
      guard = 0;
      ov0 = ov_cnt;
      fe0 = fe_cnt;
      fork
         begin
            for (int k = 0; k < n_rand; k++) begin
               b = 8'($urandom);
               exp_q.push_back(b);
               send_frame(b, 1'b1);
            end
         end
         begin
            while (popped < n_rand && guard < n_rand * B * 12 + 200) begin
               @(negedge clk);
               guard++;
               r = 1'($urandom_range(0, 1));
               ready = r;
               if (r && rx_valid === 1'b1) begin
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                  check("rand_dat", 32'(rx_dat), 32'(e));
                  popped++;
               end
            end
            @(negedge clk);
            ready = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      check("rand_count", 32'(popped), 32'(n_rand));
      check("rand_no_ovr", 32'(ov_cnt - ov0), 32'd0);
      check("rand_no_ferr", 32'(fe_cnt - fe0), 32'd0);

      // Reset during data bit 4 with a byte waiting in the FIFO
      send_frame(8'h42, 1'b1);
      exp_q.push_back(8'h42);
      repeat (2) @(negedge clk);
      check("pre_rst_valid", 32'(rx_valid), 32'd1);
      b = 8'h5A;
      rxd = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = b[i];
         repeat (B) @(negedge clk);
      end
      rxd = b[4];
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(rx_valid), 32'd0);
      check("arst_dat", 32'(rx_dat), 32'h00);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_ferr", 32'(frame_err), 32'd0);
      check("arst_ovr", 32'(overrun), 32'd0);
      exp_q.delete();
      rxd = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * B) @(negedge clk);
      check("post_rst_empty", 32'(rx_valid), 32'd0);
      send_frame(8'h7E, 1'b1);
      exp_q.push_back(8'h7E);
      repeat (2) @(negedge clk);
      pop_expect("b7e");
      check("b7e_empty", 32'(rx_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
